// File: rtl/elastic_pipe_reg.sv
// Elastic pipeline register: a head entry plus one skid entry, valid/ready
// handshake on both sides, and in_ready taken only from registered state.
// A synchronous flush empties the stage and can optionally zero the stored
// payloads. A saturating stall counter reports how often the head was blocked.
module elastic_pipe_reg #(
  parameter int WIDTH         = 32,
  parameter int ZERO_ON_FLUSH = 1,
  parameter int STALL_CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [1:0]             occupancy,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam logic [STALL_CNT_W-1:0] STALL_MAX = '1;

  // Head entry (always the one presented downstream) and skid entry
  logic                   main_valid_reg, main_valid_next;
  logic [WIDTH-1:0]       main_data_reg,  main_data_next;
  logic                   skid_valid_reg, skid_valid_next;
  logic [WIDTH-1:0]       skid_data_reg,  skid_data_next;
  logic [STALL_CNT_W-1:0] stall_cnt_reg,  stall_cnt_next;

  logic accept;
  logic drain;
  logic stall;

  // in_ready depends only on the skid valid flop, so no ready path runs
  // combinationally from out_ready to in_ready.
  assign in_ready    = !skid_valid_reg;
  assign out_valid   = main_valid_reg;
  assign out_data    = main_data_reg;
  assign occupancy   = {1'b0, main_valid_reg} + {1'b0, skid_valid_reg};
  assign stall_count = stall_cnt_reg;

  assign accept = in_valid & in_ready;
  assign drain  = main_valid_reg & out_ready;
  assign stall  = main_valid_reg & !out_ready;

  // Next-state for the two entries; the valid pair encodes EMPTY/HALF/FULL
  always_comb begin
    main_valid_next = main_valid_reg;
    main_data_next  = main_data_reg;
    skid_valid_next = skid_valid_reg;
    skid_data_next  = skid_data_reg;

    if (flush) begin
      // Everything stored is dropped and the offered input is killed.
      main_valid_next = 1'b0;
      skid_valid_next = 1'b0;
      if (ZERO_ON_FLUSH != 0) begin
        main_data_next = '0;
        skid_data_next = '0;
      end
    end else if (!main_valid_reg) begin
      // EMPTY: the incoming word goes straight to the head.
      if (accept) begin
        main_valid_next = 1'b1;
        main_data_next  = in_data;
      end
    end else if (!skid_valid_reg) begin
      // HALF: replace head on pass-through, park in skid when blocked.
      if (accept && drain) begin
        main_data_next = in_data;
      end else if (accept) begin
        skid_valid_next = 1'b1;
        skid_data_next  = in_data;
      end else if (drain) begin
        main_valid_next = 1'b0;
      end
    end else begin
      // FULL: upstream is held off; skid moves up once the head leaves.
      if (drain) begin
        main_data_next  = skid_data_reg;
        skid_valid_next = 1'b0;
      end
    end
  end

  // Saturating count of cycles where the head waited on downstream
  always_comb begin
    stall_cnt_next = stall_cnt_reg;
    if (stall && (stall_cnt_reg != STALL_MAX)) begin
      stall_cnt_next = stall_cnt_reg + STALL_CNT_W'(1);
    end
  end

  // State registers; reset overrides flush and the handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_reg <= 1'b0;
      main_data_reg  <= '0;
      skid_valid_reg <= 1'b0;
      skid_data_reg  <= '0;
      stall_cnt_reg  <= '0;
    end else begin
      main_valid_reg <= main_valid_next;
      main_data_reg  <= main_data_next;
      skid_valid_reg <= skid_valid_next;
      skid_data_reg  <= skid_data_next;
      stall_cnt_reg  <= stall_cnt_next;
    end
  end

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Directed bench for elastic_pipe_reg. Three instances share one stimulus:
// a default one, one that keeps payloads on flush, and one with a 3-bit
// stall counter for the saturation case.
module tb_elastic_pipe_reg;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_data;

  logic        in_ready_a, out_valid_a;
  logic [31:0] out_data_a;
  logic [1:0]  occ_a;
  logic [15:0] stall_a;

  logic        in_ready_z, out_valid_z;
  logic [31:0] out_data_z;
  logic [1:0]  occ_z;
  logic [15:0] stall_z;

  logic        in_ready_s, out_valid_s;
  logic [31:0] out_data_s;
  logic [1:0]  occ_s;
  logic [2:0]  stall_s;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  elastic_pipe_reg #(.WIDTH(32), .ZERO_ON_FLUSH(1), .STALL_CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_data(in_data), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_data(out_data_a), .occupancy(occ_a), .stall_count(stall_a));

  elastic_pipe_reg #(.WIDTH(32), .ZERO_ON_FLUSH(0), .STALL_CNT_W(16)) dut_z (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_z),
    .in_data(in_data), .out_valid(out_valid_z), .out_ready(out_ready),
    .out_data(out_data_z), .occupancy(occ_z), .stall_count(stall_z));

  elastic_pipe_reg #(.WIDTH(32), .ZERO_ON_FLUSH(1), .STALL_CNT_W(3)) dut_s (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_data(in_data), .out_valid(out_valid_s), .out_ready(out_ready),
    .out_data(out_data_s), .occupancy(occ_s), .stall_count(stall_s));

  // Advance one clock and settle just after the active edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 32'hDEADBEEF; out_ready = 1'b0;
    step(); step();
    total++; if (out_valid_a !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid_a); end
    total++; if (in_ready_a !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready_a); end
    total++; if (occ_a !== 2'd0) begin bad++; $display("FAIL reset_occ got=%0d exp=0", occ_a); end
    total++; if (stall_a !== 16'd0) begin bad++; $display("FAIL reset_stall got=%0d exp=0", stall_a); end
    total++; if (out_data_a !== 32'h0) begin bad++; $display("FAIL reset_out_data got=%h exp=0", out_data_a); end
    rst = 1'b0;
    step();
    total++; if (out_valid_a !== 1'b1) begin bad++; $display("FAIL first_accept_valid got=%0b exp=1", out_valid_a); end
    total++; if (out_data_a !== 32'hDEADBEEF) begin bad++; $display("FAIL first_accept_data got=%h exp=deadbeef", out_data_a); end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    total++; if (out_valid_a !== 1'b0) begin bad++; $display("FAIL first_drain_valid got=%0b exp=0", out_valid_a); end
    total++; if (stall_a !== 16'd0) begin bad++; $display("FAIL first_drain_stall got=%0d exp=0", stall_a); end
    $display("test_reset done");
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = 32'(i);
      step();
      total++; if (out_valid_a !== 1'b1 || out_data_a !== 32'(i)) begin bad++; $display("FAIL stream_out[%0d] got v=%0b d=%h exp v=1 d=%h", i, out_valid_a, out_data_a, 32'(i)); end
      total++; if (in_ready_a !== 1'b1 || occ_a !== 2'd1) begin bad++; $display("FAIL stream_ready_occ[%0d] got rdy=%0b occ=%0d exp rdy=1 occ=1", i, in_ready_a, occ_a); end
    end
    in_valid = 1'b0;
    step();
    total++; if (out_valid_a !== 1'b0) begin bad++; $display("FAIL stream_end_valid got=%0b exp=0", out_valid_a); end
    $display("test_streaming done");
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hA;
    step();
    total++; if (occ_a !== 2'd1 || out_data_a !== 32'hA) begin bad++; $display("FAIL bp_push_a got occ=%0d d=%h exp occ=1 d=a", occ_a, out_data_a); end
    in_data = 32'hB;
    step();
    total++; if (occ_a !== 2'd2 || in_ready_a !== 1'b0) begin bad++; $display("FAIL bp_full got occ=%0d rdy=%0b exp occ=2 rdy=0", occ_a, in_ready_a); end
    in_data = 32'hC;
    step(); step();
    total++; if (occ_a !== 2'd2 || out_data_a !== 32'hA) begin bad++; $display("FAIL bp_hold got occ=%0d d=%h exp occ=2 d=a", occ_a, out_data_a); end
    total++; if (stall_a !== 16'd3) begin bad++; $display("FAIL bp_stall_mid got=%0d exp=3", stall_a); end
    out_ready = 1'b1;
    step();
    total++; if (out_valid_a !== 1'b1 || out_data_a !== 32'hB || occ_a !== 2'd1) begin bad++; $display("FAIL bp_out_b got v=%0b d=%h occ=%0d exp v=1 d=b occ=1", out_valid_a, out_data_a, occ_a); end
    step();
    total++; if (out_valid_a !== 1'b1 || out_data_a !== 32'hC) begin bad++; $display("FAIL bp_out_c got v=%0b d=%h exp v=1 d=c", out_valid_a, out_data_a); end
    in_valid = 1'b0;
    step();
    total++; if (out_valid_a !== 1'b0 || occ_a !== 2'd0) begin bad++; $display("FAIL bp_empty got v=%0b occ=%0d exp v=0 occ=0", out_valid_a, occ_a); end
    total++; if (stall_a !== 16'd3) begin bad++; $display("FAIL bp_stall_end got=%0d exp=3", stall_a); end
    $display("test_backpressure done");
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h11;
    step();
    in_data = 32'h22;
    step();
    total++; if (occ_a !== 2'd2) begin bad++; $display("FAIL flush_prefill_occ got=%0d exp=2", occ_a); end
    flush = 1'b1; in_data = 32'h33;
    step();
    total++; if (out_valid_a !== 1'b0 || occ_a !== 2'd0) begin bad++; $display("FAIL flush_state got v=%0b occ=%0d exp v=0 occ=0", out_valid_a, occ_a); end
    total++; if (out_data_a !== 32'h0 || in_ready_a !== 1'b1) begin bad++; $display("FAIL flush_zero got d=%h rdy=%0b exp d=0 rdy=1", out_data_a, in_ready_a); end
    total++; if (out_valid_z !== 1'b0 || occ_z !== 2'd0) begin bad++; $display("FAIL flush_keep_state got v=%0b occ=%0d exp v=0 occ=0", out_valid_z, occ_z); end
    total++; if (out_data_z !== 32'h11) begin bad++; $display("FAIL flush_keep_data got=%h exp=11", out_data_z); end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    total++; if (out_valid_a !== 1'b0 || out_valid_z !== 1'b0) begin bad++; $display("FAIL flush_killed_input got a=%0b z=%0b exp 0 0", out_valid_a, out_valid_z); end
    total++; if (stall_a !== 16'd5) begin bad++; $display("FAIL flush_stall_kept got=%0d exp=5", stall_a); end
    $display("test_flush done");
  endtask

  task automatic test_saturation();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h5;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) step();
    total++; if (stall_s !== 3'd7) begin bad++; $display("FAIL sat_reach got=%0d exp=7", stall_s); end
    total++; if (stall_a !== 16'd15) begin bad++; $display("FAIL sat_wide got=%0d exp=15", stall_a); end
    step(); step();
    total++; if (stall_s !== 3'd7) begin bad++; $display("FAIL sat_hold got=%0d exp=7", stall_s); end
    flush = 1'b1;
    step();
    flush = 1'b0;
    total++; if (stall_s !== 3'd7 || stall_a !== 16'd18) begin bad++; $display("FAIL sat_after_flush got s=%0d a=%0d exp s=7 a=18", stall_s, stall_a); end
    $display("test_saturation done");
  endtask

  task automatic test_reset_precedence();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h77;
    step();
    total++; if (occ_a !== 2'd1) begin bad++; $display("FAIL prec_half got=%0d exp=1", occ_a); end
    rst = 1'b1; flush = 1'b1; in_data = 32'h99;
    step();
    total++; if (out_valid_a !== 1'b0 || occ_a !== 2'd0 || out_data_a !== 32'h0) begin bad++; $display("FAIL prec_state got v=%0b occ=%0d d=%h exp 0 0 0", out_valid_a, occ_a, out_data_a); end
    total++; if (stall_a !== 16'd0 || stall_s !== 3'd0) begin bad++; $display("FAIL prec_stall got a=%0d s=%0d exp 0 0", stall_a, stall_s); end
    total++; if (out_data_z !== 32'h0 || in_ready_a !== 1'b1) begin bad++; $display("FAIL prec_zdata got d=%h rdy=%0b exp d=0 rdy=1", out_data_z, in_ready_a); end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    step();
    total++; if (out_valid_a !== 1'b0 || occ_a !== 2'd0) begin bad++; $display("FAIL prec_nothing_stored got v=%0b occ=%0d exp 0 0", out_valid_a, occ_a); end
    $display("test_reset_precedence done");
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_saturation();
    test_reset_precedence();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/elastic_pipe_reg.md
Name: elastic_pipe_reg

Overview:
- Parametrised successor to the fixed ex/mem-style pipeline register. Generic WIDTH-bit payload, valid/ready handshake on both sides, 2-entry skid storage so in_ready is registered (no combinational ready path), and synchronous flush with selectable payload zeroing.
- Drop-in between any two CPU pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). Also exposes occupancy and a saturating stall counter for performance monitoring.

Parameters:
- WIDTH, 32, payload width in bits (>=1).
- ZERO_ON_FLUSH, 1, 1: flush clears stored payloads to '0 (NOP bubble); 0: flush clears only valid bits, payload registers hold.
- STALL_CNT_W, 16, width of stall_count (>=1).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  drop all stored entries and any input offered this cycle.
- in_valid  input  1  upstream payload valid.
- in_ready  output  1  stage can accept; driven from registered state only.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  head entry valid.
- out_ready  input  1  downstream accepts head.
- out_data  output  WIDTH  head payload.
- occupancy  output  2  number of valid entries (0..2).
- stall_count  output  STALL_CNT_W  cycles with out_valid=1 and out_ready=0; saturating.

Behaviour:
- Storage: main (head) and skid entries, each with data and valid. out_valid = main.valid, out_data = main.data, in_ready = !skid.valid, occupancy = main.valid + skid.valid.
- accept = in_valid & in_ready; drain = out_valid & out_ready.
- Reset (rst=1 at posedge): both valids 0, both data '0, stall_count 0. Reset has priority over flush and over the handshake. Outputs after reset: out_valid=0, out_data=0, in_ready=1, occupancy=0. Reset mid-transfer discards everything.
- States follow from the valid bits:
  - EMPTY (main=0, skid=0):
    - accept -> main<=in_data, go to HALF.
    - otherwise stay in EMPTY.
  - HALF (main=1, skid=0):
    - accept & drain -> main<=in_data, stay in HALF.
    - accept & !drain -> skid<=in_data, go to FULL.
    - !accept & drain -> main.valid<=0, go to EMPTY.
    - neither -> hold.
  - FULL (main=1, skid=1): in_ready=0.
    - drain -> main<=skid, skid.valid<=0, go to HALF.
    - otherwise hold.
- Skid invariant: skid.valid=1 implies main.valid=1. The skid entry is never presented at the output.
- Latency and throughput: 1 cycle from accept to out_valid. Sustains 1 transfer/cycle when out_ready is held high. Order strictly FIFO.
- Flush (rst=0, flush=1):
  - Next state is EMPTY.
  - Input offered in the flush cycle is not stored, even if in_ready=1. The upstream must treat it as killed.
  - Data registers are zeroed iff ZERO_ON_FLUSH=1.
  - A head shown in the flush cycle with out_ready=1 counts as delivered; downstream kills it by its own flush.
  - Flush with in_ready=0 is legal.
  - in_ready=1 on the cycle after flush.
- Payload must stay stable while stored. in_data is ignored when !accept.
- stall_count: +1 each cycle with out_valid & !out_ready. Holds at all-ones (no wrap). Cleared only by rst; flush does not clear it.
- No X on outputs after reset. Payload '0 is legal data and is not treated as a bubble.

Test Plan:
- Reset then idle: rst for 2 cycles with in_valid=1, in_data=0xDEADBEEF -> out_valid=0, in_ready=1, occupancy=0, stall_count=0. First cycle after reset accepts; out_data=0xDEADBEEF one cycle later.
- Streaming: out_ready=1, push 0x1..0x8 on consecutive cycles -> out_data 0x1..0x8 on consecutive cycles one cycle later; in_ready stays 1; occupancy stays at most 1.
- Backpressure/skid: push 0xA, 0xB, 0xC back-to-back with out_ready=0 -> occupancy reaches 2, in_ready=0, 0xC held upstream. Release out_ready: outputs 0xA, 0xB, 0xC in order with no loss or duplication. stall_count equals the cycles out_valid was 1 with out_ready=0.
- Flush while FULL with ZERO_ON_FLUSH=1 and in_valid=1: next cycle out_valid=0, occupancy=0, out_data=0, in_ready=1. The flush-cycle input is absent from the output stream. With ZERO_ON_FLUSH=0 the same sequence gives valid=0 and data unchanged.
- Saturation: STALL_CNT_W=3, hold out_valid=1 with out_ready=0 for 10 cycles -> stall_count reads 7 and stays at 7. rst returns it to 0; flush does not.
- Reset precedence: rst=1 and flush=1 together while HALF with accept pending -> all state zero, stall_count=0, no entry stored.
